// File: rtl/otter_clint_if.sv
// otter_clint_if: data-memory bus between the Otter MCU (master) and the
// CLINT timer block (slave). Timing matches program memory: synchronous
// read (data one cycle after i_re), strobed write.
//   i_re      read enable
//   i_we      write enable
//   i_sel     byte write strobes, bit n -> bits [8n+7:8n]
//   i_addr    byte address, bits [1:0] ignored
//   i_w_data  write data
//   o_hit     combinational address decode for the CLINT window
//   o_r_data  registered read data
interface otter_clint_if;
    logic        i_re;
    logic        i_we;
    logic [3:0]  i_sel;
    logic [31:0] i_addr;
    logic [31:0] i_w_data;
    logic        o_hit;
    logic [31:0] o_r_data;

    modport master (
        output i_re, i_we, i_sel, i_addr, i_w_data,
        input  o_hit, o_r_data
    );

    modport slave (
        input  i_re, i_we, i_sel, i_addr, i_w_data,
        output o_hit, o_r_data
    );
endinterface

// File: rtl/otter_clint.sv
// otter_clint: machine-mode timer (mtime/mtimecmp) and software interrupt
// (msip) for the Otter MCU, mapped in a 64 KiB window at BASE_ADDR.
//   clk       clock, rising edge
//   rst       asynchronous, active-low reset
//   bus       slave side of otter_clint_if (dmem-style read/write port)
//   o_intrpt  registered interrupt vector: bit 3 = MSIP, bit 7 = MTIP
module otter_clint #(
    parameter logic [31:0] BASE_ADDR    = 32'h0200_0000,
    parameter int unsigned PRESCALE     = 1,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic          clk,
    input  logic          rst,
    otter_clint_if.slave  bus,
    output logic [31:0]   o_intrpt
);

    localparam int unsigned    PCW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCW-1:0] PCNT_MAX = PCW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_MT_LO,
        REG_MT_HI
    } reg_sel_e;

    logic           msip_q,       msip_d;
    logic [63:0]    mtimecmp_q,   mtimecmp_d;
    logic [63:0]    mtime_q,      mtime_d;
    logic [PCW-1:0] pcnt_q,       pcnt_d;
    logic [31:0]    hi_shadow_q,  hi_shadow_d;
    logic           shadow_vld_q, shadow_vld_d;
    logic [31:0]    r_data_q,     r_data_d;
    logic           mtip_q,       mtip_d;

    reg_sel_e       reg_sel;
    logic           hit;
    logic           rd_en;
    logic           wr_en;
    logic           tick;
    logic [31:0]    rd_mux;
    logic           unused_addr_bits;

    assign unused_addr_bits = ^bus.i_addr[1:0];

    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        res = old_val;
        for (int unsigned n = 0; n < 4; n++) begin
            if (sel[n]) res[8*n +: 8] = new_val[8*n +: 8];
        end
        return res;
    endfunction

    // Address decode: only [31:16] select the window, [15:2] pick the word.
    always_comb begin
        hit     = (bus.i_addr[31:16] == BASE_ADDR[31:16]);
        reg_sel = REG_NONE;
        case (bus.i_addr[15:2])
            14'h0000: reg_sel = REG_MSIP;
            14'h1000: reg_sel = REG_CMP_LO;
            14'h1001: reg_sel = REG_CMP_HI;
            14'h2FFE: reg_sel = REG_MT_LO;
            14'h2FFF: reg_sel = REG_MT_HI;
            default:  reg_sel = REG_NONE;
        endcase
    end

    assign rd_en     = hit && bus.i_re;
    assign wr_en     = hit && bus.i_we;
    assign tick      = (pcnt_q == PCNT_MAX);
    assign bus.o_hit = hit;

    // Read mux sees pre-edge register contents, so read-during-write
    // returns the old value.
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_MSIP:   rd_mux = {31'b0, msip_q};
            REG_CMP_LO: rd_mux = mtimecmp_q[31:0];
            REG_CMP_HI: rd_mux = mtimecmp_q[63:32];
            REG_MT_LO:  rd_mux = mtime_q[31:0];
            REG_MT_HI:  rd_mux = shadow_vld_q ? hi_shadow_q : mtime_q[63:32];
            default:    rd_mux = '0;
        endcase
    end

    always_comb begin
        msip_d       = msip_q;
        mtimecmp_d   = mtimecmp_q;
        mtime_d      = mtime_q;
        pcnt_d       = pcnt_q;
        hi_shadow_d  = hi_shadow_q;
        shadow_vld_d = shadow_vld_q;
        r_data_d     = r_data_q;
        mtip_d       = (mtime_q >= mtimecmp_q);

        if (rd_en) begin
            r_data_d = rd_mux;
            if (reg_sel == REG_MT_LO) begin
                hi_shadow_d  = mtime_q[63:32];
                shadow_vld_d = 1'b1;
            end
            if (reg_sel == REG_MT_HI) shadow_vld_d = 1'b0;
        end

        // Timer advance; an mtime write overrides the increment below.
        if (tick) begin
            pcnt_d  = '0;
            mtime_d = mtime_q + 64'd1;
        end else begin
            pcnt_d  = pcnt_q + PCW'(1);
        end

        if (wr_en) begin
            shadow_vld_d = 1'b0;
            case (reg_sel)
                REG_MSIP: begin
                    if (bus.i_sel[0]) msip_d = bus.i_w_data[0];
                end
                REG_CMP_LO: mtimecmp_d[31:0]  = merge_lanes(mtimecmp_q[31:0],  bus.i_w_data, bus.i_sel);
                REG_CMP_HI: mtimecmp_d[63:32] = merge_lanes(mtimecmp_q[63:32], bus.i_w_data, bus.i_sel);
                REG_MT_LO: begin
                    mtime_d = {mtime_q[63:32], merge_lanes(mtime_q[31:0], bus.i_w_data, bus.i_sel)};
                    pcnt_d  = '0;
                end
                REG_MT_HI: begin
                    mtime_d = {merge_lanes(mtime_q[63:32], bus.i_w_data, bus.i_sel), mtime_q[31:0]};
                    pcnt_d  = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msip_q       <= 1'b0;
            mtimecmp_q   <= MTIMECMP_RST;
            mtime_q      <= '0;
            pcnt_q       <= '0;
            hi_shadow_q  <= '0;
            shadow_vld_q <= 1'b0;
            r_data_q     <= '0;
            mtip_q       <= 1'b0;
        end else begin
            msip_q       <= msip_d;
            mtimecmp_q   <= mtimecmp_d;
            mtime_q      <= mtime_d;
            pcnt_q       <= pcnt_d;
            hi_shadow_q  <= hi_shadow_d;
            shadow_vld_q <= shadow_vld_d;
            r_data_q     <= r_data_d;
            mtip_q       <= mtip_d;
        end
    end

    assign bus.o_r_data = r_data_q;
    assign o_intrpt     = {24'b0, mtip_q, 3'b0, msip_q, 3'b0};

endmodule
